// File: rtl/upperimm_li_encoder_if.sv
// rtl/upperimm_li_encoder_if.sv - request and instruction-stream bundle for the li encoder
interface upperimm_li_encoder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_pcrel;
  logic [4:0]  req_rd;
  logic [31:0] req_value;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_last;

  modport master (
    output req_valid, req_pcrel, req_rd, req_value, out_ready,
    input  req_ready, out_valid, out_instr, out_last
  );

  modport slave (
    input  req_valid, req_pcrel, req_rd, req_value, out_ready,
    output req_ready, out_valid, out_instr, out_last
  );
endinterface

// File: rtl/upperimm_li_encoder.sv
// rtl/upperimm_li_encoder.sv - expands a 32-bit constant load into LUI/AUIPC + optional ADDI words
module upperimm_li_encoder #(
  parameter int COUNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  upperimm_li_encoder_if.slave  bus,
  output logic [COUNT_W-1:0]    instr_count
);

  typedef enum logic [1:0] {IDLE, EMIT_HI, EMIT_LO} state_t;

  state_t               state_q, state_d;
  logic [4:0]           rd_q, rd_d;
  logic                 pcrel_q, pcrel_d;
  logic [19:0]          hi_q, hi_d;
  logic [11:0]          lo_q, lo_d;
  logic                 addi_follows_q, addi_follows_d;
  logic                 rs1_zero_q, rs1_zero_d;
  logic [COUNT_W-1:0]   count_q, count_d;

  logic [19:0] hi_calc;
  logic        accept;
  logic        xfer;

  // Rounding the upper part up compensates for the sign extension of the 12-bit ADDI immediate.
  assign hi_calc = bus.req_value[31:12] + {19'd0, bus.req_value[11]};

  assign bus.req_ready = (state_q == IDLE) && !rst;
  assign bus.out_valid = (state_q != IDLE);
  assign accept        = bus.req_valid && bus.req_ready;
  assign xfer          = bus.out_valid && bus.out_ready;
  assign instr_count   = count_q;

  always_comb begin
    bus.out_instr = 32'd0;
    bus.out_last  = 1'b0;
    case (state_q)
      EMIT_HI: begin
        bus.out_instr = {hi_q, rd_q, pcrel_q ? 7'b0010111 : 7'b0110111};
        bus.out_last  = !addi_follows_q;
      end
      EMIT_LO: begin
        bus.out_instr = {lo_q, rs1_zero_q ? 5'd0 : rd_q, 3'b000, rd_q, 7'b0010011};
        bus.out_last  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    rd_d           = rd_q;
    pcrel_d        = pcrel_q;
    hi_d           = hi_q;
    lo_d           = lo_q;
    addi_follows_d = addi_follows_q;
    rs1_zero_d     = rs1_zero_q;
    count_d        = count_q + {{(COUNT_W-1){1'b0}}, xfer};
    case (state_q)
      IDLE: begin
        if (accept) begin
          rd_d    = bus.req_rd;
          pcrel_d = bus.req_pcrel;
          hi_d    = hi_calc;
          lo_d    = bus.req_value[11:0];
          if (bus.req_rd == 5'd0) begin
            // Writes to x0 collapse to the canonical NOP (ADDI x0,x0,0).
            lo_d           = 12'd0;
            rs1_zero_d     = 1'b1;
            addi_follows_d = 1'b0;
            state_d        = EMIT_LO;
          end else if (!bus.req_pcrel && hi_calc == 20'd0) begin
            rs1_zero_d     = 1'b1;
            addi_follows_d = 1'b0;
            state_d        = EMIT_LO;
          end else begin
            rs1_zero_d     = 1'b0;
            addi_follows_d = (bus.req_value[11:0] != 12'd0);
            state_d        = EMIT_HI;
          end
        end
      end
      EMIT_HI: begin
        if (xfer) state_d = addi_follows_q ? EMIT_LO : IDLE;
      end
      EMIT_LO: begin
        if (xfer) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      rd_q           <= 5'd0;
      pcrel_q        <= 1'b0;
      hi_q           <= 20'd0;
      lo_q           <= 12'd0;
      addi_follows_q <= 1'b0;
      rs1_zero_q     <= 1'b0;
      count_q        <= '0;
    end else begin
      state_q        <= state_d;
      rd_q           <= rd_d;
      pcrel_q        <= pcrel_d;
      hi_q           <= hi_d;
      lo_q           <= lo_d;
      addi_follows_q <= addi_follows_d;
      rs1_zero_q     <= rs1_zero_d;
      count_q        <= count_d;
    end
  end

endmodule

// File: tb/tb_upperimm_li_encoder.sv
// tb/tb_upperimm_li_encoder.sv - directed vector bench for the li encoder
module tb_upperimm_li_encoder;

  logic        clk;
  logic        rst;
  logic [15:0] instr_count;

  upperimm_li_encoder_if bus();

  upperimm_li_encoder #(.COUNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        pcrel;
    logic [4:0]  rd;
    logic [31:0] value;
    int          nwords;
    logic [31:0] w0;
    logic [31:0] w1;
  } vec_t;

  vec_t        vecs[10];
  int          n_checks;
  int          n_fail;
  logic [15:0] exp_count;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic pcrel, input logic [4:0] rd, input logic [31:0] value);
    bus.req_valid = 1'b1;
    bus.req_pcrel = pcrel;
    bus.req_rd    = rd;
    bus.req_value = value;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_value = 32'd0;
    bus.req_rd    = 5'd0;
    bus.req_pcrel = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    chk({v.name, " req_ready idle"}, {31'd0, bus.req_ready}, 32'd1);
    bus.out_ready = 1'b1;
    drive_req(v.pcrel, v.rd, v.value);
    for (int w = 0; w < v.nwords; w++) begin
      @(negedge clk);
      chk({v.name, " out_valid"}, {31'd0, bus.out_valid}, 32'd1);
      chk({v.name, " out_instr"}, bus.out_instr, (w == 0) ? v.w0 : v.w1);
      chk({v.name, " out_last"}, {31'd0, bus.out_last}, (w == v.nwords - 1) ? 32'd1 : 32'd0);
      chk({v.name, " req_ready busy"}, {31'd0, bus.req_ready}, 32'd0);
      @(posedge clk);
      exp_count = exp_count + 16'd1;
    end
    @(negedge clk);
    chk({v.name, " out_valid done"}, {31'd0, bus.out_valid}, 32'd0);
    chk({v.name, " instr_count"}, {16'd0, instr_count}, {16'd0, exp_count});
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    exp_count = 16'd0;

    vecs[0] = '{"li_x5_12345678", 1'b0, 5'd5,  32'h12345678, 2, 32'h123452B7, 32'h67828293};
    vecs[1] = '{"li_x1_fffff800", 1'b0, 5'd1,  32'hFFFFF800, 1, 32'h80000093, 32'h0};
    vecs[2] = '{"li_x10_12000",   1'b0, 5'd10, 32'h00012000, 1, 32'h00012537, 32'h0};
    vecs[3] = '{"li_x3_fff",      1'b0, 5'd3,  32'h00000FFF, 2, 32'h000011B7, 32'hFFF18193};
    vecs[4] = '{"li_x0_nop",      1'b0, 5'd0,  32'hDEADBEEF, 1, 32'h00000013, 32'h0};
    vecs[5] = '{"pc_x0_nop",      1'b1, 5'd0,  32'h00012345, 1, 32'h00000013, 32'h0};
    vecs[6] = '{"pc_x7_1234",     1'b1, 5'd7,  32'h00001234, 2, 32'h00001397, 32'h23438393};
    vecs[7] = '{"li_x2_5",        1'b0, 5'd2,  32'h00000005, 1, 32'h00500113, 32'h0};
    vecs[8] = '{"pc_x4_80000800", 1'b1, 5'd4,  32'h80000800, 2, 32'h80001217, 32'h80020213};
    vecs[9] = '{"li_x31_minus1",  1'b0, 5'd31, 32'hFFFFFFFF, 1, 32'hFFF00F93, 32'h0};

    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_pcrel = 1'b0;
    bus.req_rd    = 5'd0;
    bus.req_value = 32'd0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset out_last", {31'd0, bus.out_last}, 32'd0);
    chk("reset out_instr", bus.out_instr, 32'd0);
    chk("reset instr_count", {16'd0, instr_count}, 32'd0);
    chk("reset req_ready", {31'd0, bus.req_ready}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Backpressure: AUIPC x6,0 must hold while the consumer stalls.
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive_req(1'b1, 5'd6, 32'h00000000);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("stall out_instr", bus.out_instr, 32'h00000317);
      chk("stall out_last", {31'd0, bus.out_last}, 32'd1);
      chk("stall req_ready", {31'd0, bus.req_ready}, 32'd0);
      chk("stall instr_count", {16'd0, instr_count}, {16'd0, exp_count});
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    exp_count = exp_count + 16'd1;
    @(negedge clk);
    chk("stall done out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("stall done instr_count", {16'd0, instr_count}, {16'd0, exp_count});

    // Reset while the ADDI of a two-word sequence is pending.
    bus.out_ready = 1'b1;
    drive_req(1'b0, 5'd5, 32'h12345678);
    @(negedge clk);
    chk("rst seq first word", bus.out_instr, 32'h123452B7);
    @(posedge clk);
    @(negedge clk);
    chk("rst seq in EMIT_LO", bus.out_instr, 32'h67828293);
    bus.out_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midrst instr_count", {16'd0, instr_count}, 32'd0);
    chk("midrst req_ready", {31'd0, bus.req_ready}, 32'd0);
    exp_count = 16'd0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post-rst req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("post-rst out_valid", {31'd0, bus.out_valid}, 32'd0);
    run_vec(vecs[3]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/upperimm_li_encoder.md
Name: upperimm_li_encoder

Overview:
- Encoder counterpart of the U-type decode path.
- Expands a "load 32-bit value into rd" request into one or two legal RV32I instruction words: LUI/AUIPC followed by an optional ADDI.
- Streams the words out over a valid/ready interface. Used by the self-test program generator and the instruction-memory loader to build constant-load sequences that the core decodes back to the original value.

Parameters:
- COUNT_W, 16, width of the emitted-instruction counter (wraps modulo 2^COUNT_W).

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  encoder can accept a request
- req_pcrel  in  1  0 = absolute load (LUI base); 1 = PC-relative (AUIPC base)
- req_rd  in  5  destination register
- req_value  in  32  value or offset to materialise
- out_valid  out  1  out_instr is valid
- out_ready  in  1  consumer accepts out_instr
- out_instr  out  32  encoded instruction word
- out_last  out  1  out_instr is the final word of the current request
- instr_count  out  COUNT_W  total instruction words handed off since reset

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset (asynchronous, immediate):
  - state=IDLE
  - out_valid=0, out_instr=0, out_last=0, instr_count=0
  - req_ready=0 while rst is high
- Applies mid-operation too: any in-flight request is dropped with no partial completion.
- FSM states: IDLE, EMIT_HI, EMIT_LO.
- req_ready = (state==IDLE) && !rst. No request is accepted while EMIT_HI or EMIT_LO is active.
- Accept: req_valid && req_ready on edge N. On that edge:
  - Register rd, pcrel and the split fields.
  - Enter the first emit state; out_valid=1 from cycle N+1 (latency 1).
- Split arithmetic:
  - lo = value[11:0], treated as signed 12-bit.
  - hi = value[31:12] + value[11], computed modulo 2^20 (carry out of bit 19 discarded).
- Sequence selection:
  - rd==0: single word 0x00000013 (canonical NOP), out_last=1.
  - pcrel=0, hi==0: single ADDI rd,x0,lo.
  - pcrel=0, lo==0, hi!=0: single LUI rd,hi.
  - pcrel=0, otherwise: LUI rd,hi then ADDI rd,rd,lo.
  - pcrel=1, lo==0: single AUIPC rd,hi (hi may be 0).
  - pcrel=1, otherwise: AUIPC rd,hi then ADDI rd,rd,lo.
- Single-word sequences that are ADDI emit from EMIT_LO; all others start in EMIT_HI.
- Encodings:
  - LUI = {hi, rd, 7'b0110111}
  - AUIPC = {hi, rd, 7'b0010111}
  - ADDI = {lo, rs1, 3'b000, rd, 7'b0010011}
- Output handshake:
  - Transfer occurs when out_valid && out_ready.
  - While out_valid && !out_ready, out_instr and out_last hold stable.
  - out_valid never drops without a transfer, except on reset.
- Transitions:
  - EMIT_HI transfer: go to EMIT_LO if an ADDI follows, else IDLE.
  - EMIT_LO transfer: go to IDLE.
  - out_valid=0 in IDLE.
- Throughput: a new request may be accepted on the cycle after the last transfer. Maximum rate is one request per 2 cycles for single-word requests.
- instr_count increments by 1 on every output transfer and wraps silently.
- out_instr contents in IDLE are don't-care; the bench must not check them.

Test Plan:
- li x5,0x12345678, out_ready=1 -> 0x123452B7 (last=0), then 0x67828293 (last=1); count=2.
- li x1,0xFFFFF800 (hi wraps to 0) -> single 0x80000093, last=1.
- li x10,0x00012000 -> single 0x00012537, last=1.
- li x3,0x00000FFF -> 0x000011B7, then 0xFFF18193.
- pcrel x6, value 0, with out_ready low for 3 cycles -> 0x00000317 held stable with out_valid=1 until out_ready; req_ready=0 throughout.
- rd=0 with any value -> 0x00000013.
- rst asserted while in EMIT_LO -> out_valid=0 and count=0 immediately; after release req_ready=1 and the next request encodes normally.
